// File: rtl/gf180mcu_fd_sc_mcu9t5v0__oai32_arc_tester_if.sv
// Bundles the signals between the OAI32 arc tester and its environment.
// master : the tester. It receives START and ZN_IN. It drives the stimulus
//          pins A1..B2 and the status outputs BUSY, DONE, PASS, FAIL_CNT and
//          FIRST_FAIL.
// slave  : the environment, meaning the cell under test plus the controller
//          that requests a run.
interface gf180mcu_fd_sc_mcu9t5v0__oai32_arc_tester_if;
    logic       START;
    logic       ZN_IN;
    logic       A1;
    logic       A2;
    logic       A3;
    logic       B1;
    logic       B2;
    logic       BUSY;
    logic       DONE;
    logic       PASS;
    logic [4:0] FAIL_CNT;
    logic [4:0] FIRST_FAIL;

    modport master (
        input  START, ZN_IN,
        output A1, A2, A3, B1, B2, BUSY, DONE, PASS, FAIL_CNT, FIRST_FAIL
    );

    modport slave (
        output START, ZN_IN,
        input  A1, A2, A3, B1, B2, BUSY, DONE, PASS, FAIL_CNT, FIRST_FAIL
    );
endinterface

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__oai32_arc_tester.sv
// Walks an OAI32 cell through its 23 timing arcs and reports failing arcs.
// Each arc is driven in three phases: toggle pin low, then high, then low.
// Each phase is held for SETTLE cycles. ZN_IN is compared against the ideal
// OAI32 response of the currently registered stimulus on the edge that
// applies the next phase.
//
// Ports
//   CLK      : rising-edge clock
//   RST      : synchronous active-high reset
//   VDD, VSS : supply pins, carried through only
//   bus      : master side of the tester interface
//              (START/ZN_IN in; A1..B2, BUSY, DONE, PASS, FAIL_CNT, FIRST_FAIL out)
//
// state | meaning
// IDLE  | waiting for START, stimulus held at 0
// P0    | toggle pin low
// P1    | toggle pin high
// P2    | toggle pin low again
// FIN   | one-cycle completion, stimulus 0, DONE set
module gf180mcu_fd_sc_mcu9t5v0__oai32_arc_tester #(
    parameter int SETTLE = 2
) (
    input  logic CLK,
    input  logic RST,
    inout  wire  VDD,
    inout  wire  VSS,
    gf180mcu_fd_sc_mcu9t5v0__oai32_arc_tester_if.master bus
);

    typedef enum logic [2:0] {IDLE, P0, P1, P2, FIN} state_t;

    localparam logic [3:0] TIMER_LOAD = 4'(SETTLE - 1);
    localparam logic [4:0] LAST_ARC   = 5'd22;
    localparam logic [4:0] NO_FAIL    = 5'd31;

    state_t     state, state_nxt;
    logic [4:0] arc, arc_nxt;
    logic [3:0] timer, timer_nxt;
    logic [4:0] stim, stim_nxt;          // {A1, A2, A3, B1, B2}
    logic       busy, busy_nxt;
    logic       done, done_nxt;
    logic [4:0] fail_cnt, fail_cnt_nxt;
    logic [4:0] first_fail, first_fail_nxt;
    logic       arc_fail, arc_fail_nxt;  // current arc already counted
    logic       exp_zn;
    logic       phase_end;
    logic       mismatch;

    logic unused_supply;
    assign unused_supply = VDD ^ VSS;

    // Arc table. Arcs 0-8 toggle A1/A2/A3 with {B1,B2} cycling 01,10,11.
    // Arcs 9-15 toggle B1 and arcs 16-22 toggle B2. In both of those ranges
    // {A1,A2,A3} steps through 001..111.
    function automatic logic [4:0] arc_vec(input logic [4:0] idx, input logic t);
        logic [4:0] v;
        logic [2:0] a;
        v = '0;
        a = '0;
        case (idx)
            5'd0:    v = {t, 1'b0, 1'b0, 2'b01};
            5'd1:    v = {t, 1'b0, 1'b0, 2'b10};
            5'd2:    v = {t, 1'b0, 1'b0, 2'b11};
            5'd3:    v = {1'b0, t, 1'b0, 2'b01};
            5'd4:    v = {1'b0, t, 1'b0, 2'b10};
            5'd5:    v = {1'b0, t, 1'b0, 2'b11};
            5'd6:    v = {1'b0, 1'b0, t, 2'b01};
            5'd7:    v = {1'b0, 1'b0, t, 2'b10};
            5'd8:    v = {1'b0, 1'b0, t, 2'b11};
            default: begin
                if (idx < 5'd16) begin
                    a = 3'(idx - 5'd8);
                    v = {a, t, 1'b0};
                end else begin
                    a = 3'(idx - 5'd15);
                    v = {a, 1'b0, t};
                end
            end
        endcase
        return v;
    endfunction

    // The expected value comes from the registered pins, so it always
    // describes the vector the cell is actually seeing.
    assign exp_zn    = ~((stim[4] | stim[3] | stim[2]) & (stim[1] | stim[0]));
    assign phase_end = (timer == 4'd0);
    assign mismatch  = (bus.ZN_IN != exp_zn);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            arc        <= '0;
            timer      <= '0;
            stim       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fail_cnt   <= '0;
            first_fail <= NO_FAIL;
            arc_fail   <= 1'b0;
        end else begin
            state      <= state_nxt;
            arc        <= arc_nxt;
            timer      <= timer_nxt;
            stim       <= stim_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            fail_cnt   <= fail_cnt_nxt;
            first_fail <= first_fail_nxt;
            arc_fail   <= arc_fail_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        arc_nxt        = arc;
        timer_nxt      = timer;
        stim_nxt       = stim;
        busy_nxt       = busy;
        done_nxt       = done;
        fail_cnt_nxt   = fail_cnt;
        first_fail_nxt = first_fail;
        arc_fail_nxt   = arc_fail;

        case (state)
            IDLE, FIN: begin
                state_nxt = IDLE;
                stim_nxt  = '0;
                busy_nxt  = 1'b0;
                // Accepting START in FIN lets a held START restart immediately.
                if (bus.START) begin
                    state_nxt      = P0;
                    arc_nxt        = '0;
                    timer_nxt      = TIMER_LOAD;
                    stim_nxt       = arc_vec(5'd0, 1'b0);
                    busy_nxt       = 1'b1;
                    done_nxt       = 1'b0;
                    fail_cnt_nxt   = '0;
                    first_fail_nxt = NO_FAIL;
                    arc_fail_nxt   = 1'b0;
                end
            end
            P0, P1, P2: begin
                if (!phase_end) begin
                    timer_nxt = timer - 4'd1;
                end else begin
                    timer_nxt = TIMER_LOAD;
                    if (mismatch && !arc_fail) begin
                        arc_fail_nxt = 1'b1;
                        fail_cnt_nxt = fail_cnt + 5'd1;
                        if (fail_cnt == 5'd0) begin
                            first_fail_nxt = arc;
                        end
                    end
                    case (state)
                        P0: begin
                            state_nxt = P1;
                            stim_nxt  = arc_vec(arc, 1'b1);
                        end
                        P1: begin
                            state_nxt = P2;
                            stim_nxt  = arc_vec(arc, 1'b0);
                        end
                        default: begin
                            if (arc == LAST_ARC) begin
                                state_nxt = FIN;
                                stim_nxt  = '0;
                                busy_nxt  = 1'b0;
                                done_nxt  = 1'b1;
                            end else begin
                                state_nxt    = P0;
                                arc_nxt      = arc + 5'd1;
                                stim_nxt     = arc_vec(arc + 5'd1, 1'b0);
                                arc_fail_nxt = 1'b0;
                            end
                        end
                    endcase
                end
            end
            default: begin
                state_nxt = IDLE;
                stim_nxt  = '0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    assign bus.A1         = stim[4];
    assign bus.A2         = stim[3];
    assign bus.A3         = stim[2];
    assign bus.B1         = stim[1];
    assign bus.B2         = stim[0];
    assign bus.BUSY       = busy;
    assign bus.DONE       = done;
    assign bus.PASS       = done & (fail_cnt == 5'd0);
    assign bus.FAIL_CNT   = fail_cnt;
    assign bus.FIRST_FAIL = first_fail;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__oai32_arc_tester.sv
// Bench for the OAI32 arc tester. Two instances are built, one with SETTLE=2
// and one with SETTLE=1. A behavioural cell model (ideal, stuck-at-0, or
// A3-ignored) closes the loop on ZN_IN. Expected stimulus vectors and run
// results are queued when START is driven. They are popped as the DUT
// produces each phase and when it reaches FIN.
module tb_gf180mcu_fd_sc_mcu9t5v0__oai32_arc_tester;

    typedef struct {
        logic [4:0] fc;
        logic [4:0] ff;
        logic       pass;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    wire  vdd;
    wire  vss;
    assign vdd = 1'b1;
    assign vss = 1'b0;

    int mode = 0;
    int sel  = 0;
    int n_cmp = 0;
    int n_bad = 0;

    logic [4:0] vq[$];
    res_t       rq[$];

    gf180mcu_fd_sc_mcu9t5v0__oai32_arc_tester_if bus0();
    gf180mcu_fd_sc_mcu9t5v0__oai32_arc_tester_if bus1();

    gf180mcu_fd_sc_mcu9t5v0__oai32_arc_tester #(.SETTLE(2)) u_dut0 (
        .CLK(clk), .RST(rst), .VDD(vdd), .VSS(vss), .bus(bus0)
    );

    gf180mcu_fd_sc_mcu9t5v0__oai32_arc_tester #(.SETTLE(1)) u_dut1 (
        .CLK(clk), .RST(rst), .VDD(vdd), .VSS(vss), .bus(bus1)
    );

    always #5 clk = ~clk;

    // v = {A1, A2, A3, B1, B2}; mode 0 ideal, 1 stuck-at-0, 2 ignores A3
    function automatic logic cell_zn(input int m, input logic [4:0] v);
        logic a_or;
        logic b_or;
        b_or = v[1] | v[0];
        a_or = v[4] | v[3] | v[2];
        if (m == 2) a_or = v[4] | v[3];
        if (m == 1) return 1'b0;
        return ~(a_or & b_or);
    endfunction

    assign bus0.ZN_IN = cell_zn(mode, {bus0.A1, bus0.A2, bus0.A3, bus0.B1, bus0.B2});
    assign bus1.ZN_IN = cell_zn(mode, {bus1.A1, bus1.A2, bus1.A3, bus1.B1, bus1.B2});

    logic [4:0] o_vec, o_fc, o_ff;
    logic       o_busy, o_done, o_pass;

    always_comb begin
        o_vec  = {bus0.A1, bus0.A2, bus0.A3, bus0.B1, bus0.B2};
        o_fc   = bus0.FAIL_CNT;
        o_ff   = bus0.FIRST_FAIL;
        o_busy = bus0.BUSY;
        o_done = bus0.DONE;
        o_pass = bus0.PASS;
        if (sel == 1) begin
            o_vec  = {bus1.A1, bus1.A2, bus1.A3, bus1.B1, bus1.B2};
            o_fc   = bus1.FAIL_CNT;
            o_ff   = bus1.FIRST_FAIL;
            o_busy = bus1.BUSY;
            o_done = bus1.DONE;
            o_pass = bus1.PASS;
        end
    end

    // Arc table written out from the pin-toggle description
    function automatic logic [4:0] exp_vec(input int arc, input bit t);
        logic [2:0] a;
        logic [1:0] b;
        if (arc < 9) begin
            a = t ? (3'b100 >> (arc / 3)) : 3'b000;
            b = 2'(arc % 3 + 1);
        end else if (arc < 16) begin
            a = 3'(arc - 8);
            b = {t, 1'b0};
        end else begin
            a = 3'(arc - 15);
            b = {1'b0, t};
        end
        return {a, b};
    endfunction

    task automatic set_start(input int s, input logic v);
        if (s == 1) bus1.START = v;
        else        bus0.START = v;
    endtask

    // Runs one full test from START to IDLE and checks every busy cycle.
    task automatic run_check(input int s, input int m, input int settle, input bit noise,
                             input logic [4:0] efc, input logic [4:0] eff);
        int         busy_cnt;
        logic [4:0] cur;
        res_t       r;
        sel  = s;
        mode = m;
        vq.delete();
        for (int a = 0; a < 23; a++) begin
            for (int p = 0; p < 3; p++) vq.push_back(exp_vec(a, p == 1));
        end
        rq.push_back('{efc, eff, efc == 5'd0});
        @(negedge clk);
        set_start(s, 1'b1);
        @(negedge clk);
        set_start(s, 1'b0);
        busy_cnt = 0;
        cur = 5'h1f;
        n_cmp++;
        if (o_done !== 1'b0 || o_fc !== 5'd0 || o_ff !== 5'd31) begin
            n_bad++;
            $display("FAIL start_status s=%0d got done=%b fc=%0d ff=%0d want done=0 fc=0 ff=31",
                     s, o_done, o_fc, o_ff);
        end
        while (o_busy === 1'b1 && busy_cnt < 69 * settle + 20) begin
            if (busy_cnt % settle == 0) begin
                if (vq.size() > 0) cur = vq.pop_front();
                else cur = 5'h1f;
            end
            n_cmp++;
            if (o_vec !== cur) begin
                n_bad++;
                $display("FAIL stim s=%0d cycle=%0d got %b want %b", s, busy_cnt, o_vec, cur);
            end
            if (noise) begin
                if (busy_cnt == 9 || busy_cnt == 57 || busy_cnt == 58) set_start(s, 1'b1);
                else set_start(s, 1'b0);
            end
            busy_cnt++;
            @(negedge clk);
        end
        set_start(s, 1'b0);
        r = rq.pop_front();
        n_cmp++;
        if (busy_cnt != 69 * settle) begin
            n_bad++;
            $display("FAIL busy_len s=%0d got %0d want %0d", s, busy_cnt, 69 * settle);
        end
        n_cmp++;
        if (vq.size() != 0) begin
            n_bad++;
            $display("FAIL phases_left s=%0d got %0d want 0", s, vq.size());
        end
        n_cmp++;
        if (o_done !== 1'b1 || o_busy !== 1'b0 || o_vec !== 5'b0) begin
            n_bad++;
            $display("FAIL fin_state s=%0d got done=%b busy=%b vec=%b want 1 0 00000",
                     s, o_done, o_busy, o_vec);
        end
        n_cmp++;
        if (o_fc !== r.fc) begin
            n_bad++;
            $display("FAIL fail_cnt s=%0d mode=%0d got %0d want %0d", s, m, o_fc, r.fc);
        end
        n_cmp++;
        if (o_ff !== r.ff) begin
            n_bad++;
            $display("FAIL first_fail s=%0d mode=%0d got %0d want %0d", s, m, o_ff, r.ff);
        end
        n_cmp++;
        if (o_pass !== r.pass) begin
            n_bad++;
            $display("FAIL pass s=%0d mode=%0d got %b want %b", s, m, o_pass, r.pass);
        end
        @(negedge clk);
        n_cmp++;
        if (o_done !== 1'b1 || o_busy !== 1'b0 || o_pass !== r.pass || o_vec !== 5'b0) begin
            n_bad++;
            $display("FAIL idle_hold s=%0d got done=%b busy=%b pass=%b vec=%b want 1 0 %b 00000",
                     s, o_done, o_busy, o_pass, o_vec, r.pass);
        end
    endtask

    task automatic test_reset();
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #1;
            n_cmp++;
            if (o_vec !== 5'b0 || o_busy !== 1'b0 || o_done !== 1'b0 || o_pass !== 1'b0 ||
                o_fc !== 5'd0 || o_ff !== 5'd31) begin
                n_bad++;
                $display("FAIL reset_vals s=%0d got vec=%b busy=%b done=%b pass=%b fc=%0d ff=%0d want 0 0 0 0 0 31",
                         s, o_vec, o_busy, o_done, o_pass, o_fc, o_ff);
            end
        end
        sel = 0;
        set_start(0, 1'b1);
        @(negedge clk);
        n_cmp++;
        if (o_busy !== 1'b0 || o_vec !== 5'b0) begin
            n_bad++;
            $display("FAIL rst_over_start got busy=%b vec=%b want 0 00000", o_busy, o_vec);
        end
        set_start(0, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (o_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_no_start got busy=%b want 0", o_busy);
        end
    endtask

    task automatic test_good_run();
        run_check(0, 0, 2, 1'b0, 5'd0, 5'd31);
    endtask

    task automatic test_stuck0();
        run_check(0, 1, 2, 1'b0, 5'd23, 5'd0);
    endtask

    task automatic test_ignore_a3();
        run_check(0, 2, 2, 1'b0, 5'd5, 5'd6);
    endtask

    task automatic test_mid_reset();
        sel  = 0;
        mode = 1;
        @(negedge clk);
        set_start(0, 1'b1);
        @(negedge clk);
        set_start(0, 1'b0);
        repeat (50) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (o_vec !== 5'b0 || o_busy !== 1'b0 || o_done !== 1'b0 || o_pass !== 1'b0 ||
            o_fc !== 5'd0 || o_ff !== 5'd31) begin
            n_bad++;
            $display("FAIL mid_reset got vec=%b busy=%b done=%b pass=%b fc=%0d ff=%0d want 0 0 0 0 0 31",
                     o_vec, o_busy, o_done, o_pass, o_fc, o_ff);
        end
        run_check(0, 0, 2, 1'b0, 5'd0, 5'd31);
    endtask

    task automatic test_start_mid_run();
        run_check(0, 0, 2, 1'b1, 5'd0, 5'd31);
    endtask

    task automatic test_back_to_back();
        int cnt;
        sel  = 0;
        mode = 0;
        @(negedge clk);
        set_start(0, 1'b1);
        @(negedge clk);
        cnt = 0;
        while (o_busy === 1'b1 && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        n_cmp++;
        if (cnt != 138 || o_done !== 1'b1 || o_pass !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_first got len=%0d done=%b pass=%b want 138 1 1", cnt, o_done, o_pass);
        end
        @(negedge clk);
        set_start(0, 1'b0);
        n_cmp++;
        if (o_busy !== 1'b1 || o_done !== 1'b0 || o_vec !== exp_vec(0, 1'b0) ||
            o_fc !== 5'd0 || o_ff !== 5'd31) begin
            n_bad++;
            $display("FAIL b2b_restart got busy=%b done=%b vec=%b fc=%0d ff=%0d want 1 0 %b 0 31",
                     o_busy, o_done, o_vec, o_fc, o_ff, exp_vec(0, 1'b0));
        end
        cnt = 0;
        while (o_busy === 1'b1 && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        n_cmp++;
        if (cnt != 138 || o_done !== 1'b1 || o_pass !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_second got len=%0d done=%b pass=%b want 138 1 1", cnt, o_done, o_pass);
        end
        @(negedge clk);
    endtask

    task automatic test_settle1();
        run_check(1, 0, 1, 1'b0, 5'd0, 5'd31);
    endtask

    initial begin
        rst = 1'b1;
        bus0.START = 1'b0;
        bus1.START = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_good_run();
        test_stuck0();
        test_ignore_a3();
        test_mid_reset();
        test_start_mid_run();
        test_back_to_back();
        test_settle1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
